bias_dac_slew_ctrl: RTL and testbench

- Digital front end for the R-2R bias DACs that set the SVF fc and Q bias.
- Generalised to NCH channels of WIDTH bits each.
- Each channel has a double-buffered shadow/target pair. A single commit applies all channels atomically.
- Each channel's output code is slew-limited: it moves one LSB per prescaler tick toward its target, so the filter sweeps without zipper steps.
- Sits between the register file and the analog DAC macro(s). Channel 0 drives fc, channel 1 drives Q in the 2-channel build.

---
 rtl/bias_dac_pkg.sv | 23 ++
 rtl/bias_dac_slew_ctrl_if.sv | 31 +++
 rtl/bias_dac_slew_ch.sv | 66 ++++++
 rtl/bias_dac_slew_ctrl.sv | 73 +++++++
 tb/tb_bias_dac_slew_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_dac_pkg.sv
// Shared defaults, channel roles and helpers for the slew-limited bias DAC front end.
package bias_dac_pkg;

    localparam int unsigned DEF_NCH        = 2;
    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_DIV_W      = 8;
    localparam int unsigned DEF_RESET_CODE = 0;

    // Channel roles in the 2-channel SVF build
    localparam int unsigned CH_FC = 0;
    localparam int unsigned CH_Q  = 1;

    typedef enum logic [1:0] {
        DirHold,
        DirUp,
        DirDown
    } step_dir_e;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bias_dac_slew_ctrl_if.sv
// Register-file side of the bias DAC controller: shadow writes, commit, divisor and DAC outputs.
interface bias_dac_slew_ctrl_if
    import bias_dac_pkg::*;
#(
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) ();

    localparam int unsigned CH_W = ch_idx_w(NCH);

    logic                   wr_en;
    logic [CH_W-1:0]        wr_ch;
    logic [WIDTH-1:0]       wr_data;
    logic                   commit;
    logic [DIV_W-1:0]       slew_div;
    logic [NCH*WIDTH-1:0]   dac_code;
    logic [NCH-1:0]         busy;
    logic                   settled;

    modport master (
        output wr_en, wr_ch, wr_data, commit, slew_div,
        input  dac_code, busy, settled
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, commit, slew_div,
        output dac_code, busy, settled
    );

endinterface

// File: rtl/bias_dac_slew_ch.sv
// One DAC channel: shadow/target double buffer and a code that walks one LSB per tick.
module bias_dac_slew_ch
    import bias_dac_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned RESET_CODE = DEF_RESET_CODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             tick,
    input  logic             immediate,
    output logic [WIDTH-1:0] code,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RST_CODE = WIDTH'(RESET_CODE);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] code_q, code_d;
    step_dir_e        dir;

    always_comb begin
        shadow_d = wr_en ? wr_data : shadow_q;
        // A same-edge write is visible to the commit
        target_d = commit ? shadow_d : target_q;

        if (code_q < target_q) begin
            dir = DirUp;
        end else if (code_q > target_q) begin
            dir = DirDown;
        end else begin
            dir = DirHold;
        end

        code_d = code_q;
        if (immediate) begin
            code_d = target_d;
        end else if (tick) begin
            case (dir)
                DirUp:   code_d = code_q + WIDTH'(1);
                DirDown: code_d = code_q - WIDTH'(1);
                default: code_d = code_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RST_CODE;
            target_q <= RST_CODE;
            code_q   <= RST_CODE;
        end else begin
            shadow_q <= shadow_d;
            target_q <= target_d;
            code_q   <= code_d;
        end
    end

    assign code = code_q;
    assign busy = (code_q != target_q);

endmodule

// File: rtl/bias_dac_slew_ctrl.sv
// Bias DAC front end: write decode, shared slew prescaler, atomic commit and settle pulse.
module bias_dac_slew_ctrl
    import bias_dac_pkg::*;
#(
    parameter int unsigned NCH        = DEF_NCH,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned RESET_CODE = DEF_RESET_CODE
) (
    input logic                 clk,
    input logic                 rst_n,
    bias_dac_slew_ctrl_if.slave bus
);

    localparam int unsigned CH_W = ch_idx_w(NCH);

    logic [DIV_W-1:0]            psc_q, psc_d;
    logic                        immediate;
    logic                        tick;
    logic [NCH-1:0]              busy_vec;
    logic [NCH-1:0][WIDTH-1:0]   codes;
    logic                        busy_any_q;
    logic                        settled_q;

    always_comb begin
        immediate = (bus.slew_div == '0);
        // A commit restarts the prescaler, so it never ticks on the commit edge
        tick = !immediate && !bus.commit && (psc_q >= bus.slew_div - DIV_W'(1));

        psc_d = psc_q + DIV_W'(1);
        if (bus.commit || immediate || tick) begin
            psc_d = '0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_sel;
        // Indices at or above NCH match no channel and are dropped
        assign wr_sel = bus.wr_en && (bus.wr_ch == CH_W'(i));

        bias_dac_slew_ch #(
            .WIDTH      (WIDTH),
            .RESET_CODE (RESET_CODE)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_sel),
            .wr_data   (bus.wr_data),
            .commit    (bus.commit),
            .tick      (tick),
            .immediate (immediate),
            .code      (codes[i]),
            .busy      (busy_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q      <= '0;
            busy_any_q <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            psc_q      <= psc_d;
            busy_any_q <= |busy_vec;
            settled_q  <= busy_any_q && !(|busy_vec);
        end
    end

    assign bus.dac_code = codes;
    assign bus.busy     = busy_vec;
    assign bus.settled  = settled_q;

endmodule

// File: tb/tb_bias_dac_slew_ctrl.sv
// Scoreboard bench for bias_dac_slew_ctrl: ramp arithmetic model plus expected settle events.
module tb_bias_dac_slew_ctrl;
    import bias_dac_pkg::*;

    localparam int unsigned NCH        = 3;
    localparam int unsigned WIDTH      = 4;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned RESET_CODE = 0;
    localparam int unsigned CH_W       = ch_idx_w(NCH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bias_dac_slew_ctrl_if #(.NCH(NCH), .WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    bias_dac_slew_ctrl #(
        .NCH        (NCH),
        .WIDTH      (WIDTH),
        .DIV_W      (DIV_W),
        .RESET_CODE (RESET_CODE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: each channel moves linearly from m_start toward m_tgt, one LSB per m_div edges after m_e
    int m_shadow[NCH];
    int m_start[NCH];
    int m_tgt[NCH];
    int m_e   = 0;
    int m_div = 0;

    typedef struct {
        int at;
        int codes;
    } exp_t;
    exp_t sb[$];

    function automatic int exp_code(input int i, input int c);
        int d, n;
        if (m_div == 0) return m_tgt[i];
        d = m_tgt[i] - m_start[i];
        n = (c - m_e) / m_div;
        if (d >= 0) return m_start[i] + ((n < d) ? n : d);
        return m_start[i] - ((n < -d) ? n : -d);
    endfunction

    function automatic int exp_flat(input int c);
        int v = 0;
        for (int i = 0; i < NCH; i++) v |= exp_code(i, c) << (i * WIDTH);
        return v;
    endfunction

    function automatic int tgt_flat();
        int v = 0;
        for (int i = 0; i < NCH; i++) v |= m_tgt[i] << (i * WIDTH);
        return v;
    endfunction

    function automatic int exp_busy(input int c);
        int v = 0;
        for (int i = 0; i < NCH; i++) if (exp_code(i, c) != m_tgt[i]) v |= 1 << i;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = RESET_CODE;
            m_start[i]  = RESET_CODE;
            m_tgt[i]    = RESET_CODE;
        end
        m_e   = cyc;
        m_div = 0;
        sb.delete();
    endtask

    // Called right after the commit edge; state before that edge is the model at cyc-1
    task automatic apply_commit();
        int c = cyc;
        int was_busy, maxd, d;
        int pc[NCH];
        was_busy = exp_busy(c - 1);
        maxd = 0;
        for (int i = 0; i < NCH; i++) pc[i] = exp_code(i, c - 1);
        for (int i = 0; i < NCH; i++) begin
            m_start[i] = pc[i];
            m_tgt[i]   = m_shadow[i];
            d = (m_tgt[i] > pc[i]) ? m_tgt[i] - pc[i] : pc[i] - m_tgt[i];
            if (d > maxd) maxd = d;
        end
        m_e   = c;
        m_div = int'(bus.slew_div);
        if (was_busy != 0 && sb.size() > 0) void'(sb.pop_back());
        if (was_busy != 0 || (m_div != 0 && maxd > 0)) begin
            exp_t e;
            e.at    = c + ((m_div == 0) ? 0 : maxd * m_div) + 1;
            e.codes = tgt_flat();
            sb.push_back(e);
        end
    endtask

    // All stimulus tasks start and end one time unit after a rising edge
    task automatic cycle(input int we, input int ch, input int data, input int cm);
        bus.wr_en   = (we != 0);
        bus.wr_ch   = CH_W'(ch);
        bus.wr_data = WIDTH'(data);
        bus.commit  = (cm != 0);
        @(posedge clk);
        #1;
        if (we != 0 && ch < NCH) m_shadow[ch] = data;
        if (cm != 0) apply_commit();
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_code0(input int code, input string name);
        int n = 0;
        while (exp_code(0, cyc) != code && n < 200) begin
            idle(1);
            n++;
        end
        check(name, int'(bus.dac_code[WIDTH-1:0]), code);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_code", int'(bus.dac_code), exp_flat(-1) & 0 | RESET_CODE * 0);
        check("async_rst_busy", int'(bus.busy), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("dac_code", int'(bus.dac_code), exp_flat(cyc));
        check("busy", int'(bus.busy), exp_busy(cyc));
        if (sb.size() > 0 && sb[0].at == cyc) begin
            check("settled", int'(bus.settled), 1);
            check("settle_code", int'(bus.dac_code), sb[0].codes);
            void'(sb.pop_front());
        end else begin
            check("settled_idle", int'(bus.settled), 0);
        end
    end

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_data  = '0;
        bus.commit   = 1'b0;
        bus.slew_div = '0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        // Immediate mode
        bus.slew_div = '0;
        cycle(1, 0, 9, 0);
        cycle(1, 1, 3, 0);
        cycle(0, 0, 0, 1);
        check("imm_ch0", int'(bus.dac_code[WIDTH-1:0]), 9);
        check("imm_ch1", int'(bus.dac_code[2*WIDTH-1:WIDTH]), 3);
        idle(3);

        // Full-scale ramp up and back down
        bus.slew_div = DIV_W'(4);
        cycle(1, 0, 15, 0);
        cycle(0, 0, 0, 1);
        idle(65);
        cycle(1, 0, 0, 1);
        idle(65);

        // Same-edge write and commit on channel 1
        cycle(1, 1, 7, 1);
        idle(20);

        // Out-of-range channel index is ignored
        cycle(1, 3, 5, 0);
        cycle(0, 0, 0, 1);
        idle(3);

        // Retarget mid-ramp at code 5
        cycle(1, 0, 12, 1);
        wait_code0(5, "retarget_at5");
        cycle(1, 0, 2, 1);
        idle(30);

        // Reset mid-ramp at code 8, then restart
        cycle(1, 0, 15, 1);
        wait_code0(8, "reset_at8");
        do_reset();
        idle(2);
        cycle(1, 0, 10, 1);
        idle(45);

        // Randomised writes, commits and divisors
        repeat (25) begin
            if (exp_busy(cyc) == 0) bus.slew_div = DIV_W'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) cycle(1, $urandom_range(0, NCH), $urandom_range(0, 15), 0);
            cycle($urandom_range(0, 1), $urandom_range(0, NCH - 1), $urandom_range(0, 15), 1);
            idle($urandom_range(1, 40));
        end
        idle(100);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
